uart_packet_loader: RTL and testbench
=====================================

// Module: uart_packet_loader
// PURPOSE
//  Packet-level controller behind the UART byte buffer (rx_data_ready/r_out) in the VGA convolution design.
//  Parses byte stream [SYNC][CMD][LEN_HI][LEN_LO][payload x LEN][CHK*] and sequences payload bytes into
//  either the frame pixel memory or the 3x3 kernel coefficient memory. Flags malformed/stalled packets.
// PARAMETERS
//  DATA_WIDTH      8          byte width of rx data and memory write data
//  ADDR_WIDTH      17         write address width (covers 320x240 = 76800 pixels)
//  KERNEL_DEPTH    9          max payload length for kernel command
//  SYNC_BYTE       8'hA5      packet start marker
//  TIMEOUT_CYCLES  1_000_000  max idle cycles between bytes inside a packet
// PORTS
//  clock          in   1           system clock
//  reset          in   1           synchronous, active-high
//  rx_data_ready  in   1           byte-valid level from UART byte buffer (held high several cycles per byte)
//  r_out          in   DATA_WIDTH  received byte, stable while rx_data_ready high
//  mem_we         out  1           one-cycle write strobe
//  mem_sel        out  1           0 = frame memory, 1 = kernel memory
//  mem_addr       out  ADDR_WIDTH  write address, 0-based per packet
//  mem_wdata      out  DATA_WIDTH  write data
//  busy           out  1           high in any state other than IDLE
//  pkt_done       out  1           one-cycle pulse: packet completed successfully
//  pkt_err        out  1           one-cycle pulse: packet aborted
//  err_code       out  2           0 none, 1 bad CMD/LEN, 2 timeout, 3 checksum; holds until next packet start
// BEHAVIOUR
//  - One clock; reset synchronous active-high. Reset: all outputs 0, state IDLE, counters 0.
//  - Byte accept = rising edge of rx_data_ready (registered previous value); one byte per edge, level ignored.
//  - FSM: IDLE -> CMD -> LEN_HI -> LEN_LO -> PAYLOAD -> [CHECK] -> IDLE.
//    IDLE: byte == SYNC_BYTE -> CMD, clear err_code; other bytes silently discarded.
//    CMD: 8'h01 -> frame target, 8'h02 -> kernel target; anything else -> pkt_err, err_code=1, IDLE.
//    LEN_HI/LEN_LO: LEN = {hi,lo}. LEN==0, LEN > 2**ADDR_WIDTH, or kernel LEN > KERNEL_DEPTH -> err 1, IDLE.
//    PAYLOAD: byte accepted at cycle N -> mem_we=1 at N+1 with mem_addr=index, mem_wdata=byte;
//      index increments after each write; last byte (index==LEN-1) -> CHECK or completion.
//  - Completion: pkt_done pulses the cycle after the last write (or after CHECK pass); busy drops same cycle.
//  - mem_addr/mem_wdata hold last value when mem_we=0; mem_sel fixed from CMD until next packet.
//  - Timeout: idle counter resets on every accepted byte, counts only when busy; reaching TIMEOUT_CYCLES
//    -> pkt_err, err_code=2, IDLE. Byte edge in same cycle as expiry: byte wins, counter clears.
//  - A SYNC_BYTE inside a packet is data, never a resync. Writes already issued are not rolled back on error.
//  - pkt_done and pkt_err never assert in the same cycle; reset mid-packet aborts with no pulse, no further write.
// CONFIGURATION
//  UART_LOADER_CHECKSUM_EN defined: after payload expect CHK = (CMD+LEN_HI+LEN_LO+sum payload) mod 256;
//    match -> pkt_done; mismatch -> pkt_err, err_code=3. CHECK state present, timeout applies there.
//  Not defined: no CHECK state, no checksum accumulator; pkt_done follows last payload write; err_code 3 unused.
// STRUCTURE
//  Package uart_loader_pkg: state enum, CMD_FRAME/CMD_KERNEL constants, err_code enum, SYNC default.
//  Sub-module uart_timeout_counter (clear, enable, expired) instantiated once; rest flat in this module.
// TESTING
//  1 A5 01 00 03 10 20 30 -> 3 writes sel=0 addr 0,1,2 data 10,20,30; pkt_done once; busy 0 after.
//  2 A5 02 00 0A ... -> pkt_err, err_code=1, no mem_we (LEN 10 > KERNEL_DEPTH); then A5 02 00 09 + 9 bytes ok.
//  3 A5 01 00 05 + 2 bytes then silence (TIMEOUT_CYCLES=100 in bench) -> pkt_err at 100 idle cycles, err_code=2.
//  4 CHECKSUM_EN: A5 01 00 01 7F CHK=81 -> pkt_done; CHK=80 -> pkt_err, err_code=3, write of 7F still issued.
//  5 Noise 00 FF 12 before A5 01 00 01 A5 -> noise ignored; payload A5 written at addr 0; pkt_done.
//  6 reset asserted after 2 payload bytes -> outputs 0 next cycle, no pulse; new packet parses normally.

Source files
------------

// File: rtl/uart_packet_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_loader_pkg
// Shared types and constants for the UART packet loader.
//   state_e      : loader FSM states (ST_CHECK exists only with checksum build)
//   err_code_e   : error code reported on err_code
//   CMD_FRAME    : command byte selecting frame pixel memory
//   CMD_KERNEL   : command byte selecting kernel coefficient memory
//   SYNC_DEFAULT : default packet start marker
//   len_valid()  : header length legality check
// Build option: UART_LOADER_CHECKSUM_EN adds the trailing checksum byte.
// -----------------------------------------------------------------------------
package uart_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_PAYLOAD,
      ST_DONE
`ifdef UART_LOADER_CHECKSUM_EN
      , ST_CHECK
`endif
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_BAD_HDR  = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_CHECKSUM = 2'd3
   } err_code_e;

   localparam logic [7:0] CMD_FRAME    = 8'h01;
   localparam logic [7:0] CMD_KERNEL   = 8'h02;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // A length is legal when non-zero, fits the address space and, for the
   // kernel target, fits the coefficient memory.
   function automatic logic len_valid(input logic [31:0] len,
                                      input logic        kernel,
                                      input int unsigned max_len,
                                      input int unsigned depth);
      return (len != 32'd0) && (len <= max_len) && (!kernel || (len <= depth));
   endfunction

endpackage

// File: rtl/uart_packet_loader_if.sv
// -----------------------------------------------------------------------------
// uart_packet_loader_if
// Byte-in / memory-write-out bus of the packet loader.
//   rx_data_ready : byte-valid level from the UART byte buffer
//   r_out         : received byte, stable while rx_data_ready is high
//   mem_we        : one-cycle write strobe
//   mem_sel       : 0 = frame memory, 1 = kernel memory
//   mem_addr      : write address (0-based per packet)
//   mem_wdata     : write data
// Handshake: there is no ready path. A byte is taken once per rising edge of
// rx_data_ready; every cycle with mem_we high is exactly one memory write.
// modport master = loader side, modport slave = byte buffer / memory side.
// Build option UART_LOADER_CHECKSUM_EN does not change this interface.
// -----------------------------------------------------------------------------
interface uart_packet_loader_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 17
);
   logic                  rx_data_ready;
   logic [DATA_WIDTH-1:0] r_out;
   logic                  mem_we;
   logic                  mem_sel;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   modport master (
      input  rx_data_ready, r_out,
      output mem_we, mem_sel, mem_addr, mem_wdata
   );

   modport slave (
      output rx_data_ready, r_out,
      input  mem_we, mem_sel, mem_addr, mem_wdata
   );
endinterface

// File: rtl/uart_packet_loader_timeout_counter.sv
// -----------------------------------------------------------------------------
// uart_timeout_counter
// Counts idle cycles while enabled; expired_o flags the LIMIT-th consecutive
// idle cycle. clear_i has priority and suppresses expiry in the same cycle.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : restart the idle count
//   enable_i     : count this cycle
//   expired_o    : idle limit reached
// Build option UART_LOADER_CHECKSUM_EN does not affect this block.
// -----------------------------------------------------------------------------
module uart_timeout_counter #(
   parameter int unsigned LIMIT = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_q, count_d;

   assign expired_o = enable_i && !clear_i && (count_q == CW'(LIMIT - 1));

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/uart_packet_loader.sv
// -----------------------------------------------------------------------------
// uart_packet_loader
// Parses [SYNC][CMD][LEN_HI][LEN_LO][payload x LEN][CHK] from the UART byte
// buffer and writes the payload into frame memory (CMD 01) or kernel memory
// (CMD 02). Malformed or stalled packets are aborted with pkt_err/err_code.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : uart_packet_loader_if.master (rx byte in, memory write out)
//   busy         : high whenever the FSM is not idle
//   pkt_done     : one-cycle pulse on successful completion
//   pkt_err      : one-cycle pulse on abort
//   err_code     : 0 none, 1 bad CMD/LEN, 2 timeout, 3 checksum; held until
//                  the next SYNC byte
//   dbg_state_o  : current FSM state
// Build option: UART_LOADER_CHECKSUM_EN enables the CHK byte and CHECK state.
// -----------------------------------------------------------------------------
module uart_packet_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH     = 8,
   parameter int unsigned           ADDR_WIDTH     = 17,
   parameter int unsigned           KERNEL_DEPTH   = 9,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = DATA_WIDTH'(SYNC_DEFAULT),
   parameter int unsigned           TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  clock,
   input  logic                  reset,
   uart_packet_loader_if.master  bus,
   output logic                  busy,
   output logic                  pkt_done,
   output logic                  pkt_err,
   output logic [1:0]            err_code,
   output state_e                dbg_state_o
);
   localparam int unsigned MAX_LEN = 1 << ADDR_WIDTH;

   state_e                  state_q;
   err_code_e               err_code_q;
   logic                    rx_prev_q;
   logic                    mem_we_q, mem_sel_q, pkt_done_q, pkt_err_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, idx_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, len_hi_q;
   logic [2*DATA_WIDTH-1:0] len_q;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   sum_q;
`endif

   logic byte_acc, last_byte, timeout, to_clear;

   // Only the rising edge of the byte-valid level is a new byte.
   assign byte_acc  = bus.rx_data_ready && !rx_prev_q;
   assign last_byte = (32'(idx_q) + 32'd1) == 32'(len_q);
   assign to_clear  = byte_acc || (state_q == ST_IDLE);

   uart_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk_i     (clock),
      .rst_i     (reset),
      .clear_i   (to_clear),
      .enable_i  (busy),
      .expired_o (timeout)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         err_code_q  <= ERR_NONE;
         rx_prev_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_sel_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         pkt_done_q  <= 1'b0;
         pkt_err_q   <= 1'b0;
         idx_q       <= '0;
         len_q       <= '0;
         len_hi_q    <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         rx_prev_q  <= bus.rx_data_ready;
         mem_we_q   <= 1'b0;
         pkt_done_q <= 1'b0;
         pkt_err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (byte_acc && (bus.r_out == SYNC_BYTE)) begin
                  state_q    <= ST_CMD;
                  err_code_q <= ERR_NONE;
               end
            end
            // One cycle after the last write; bytes arriving here are dropped.
            ST_DONE: begin
               pkt_done_q <= 1'b1;
               state_q    <= ST_IDLE;
            end
            default: begin
               // An accepted byte always beats a simultaneous timeout.
               if (byte_acc) begin
                  case (state_q)
                     ST_CMD: begin
                        if (bus.r_out == DATA_WIDTH'(CMD_FRAME) ||
                            bus.r_out == DATA_WIDTH'(CMD_KERNEL)) begin
                           mem_sel_q <= (bus.r_out == DATA_WIDTH'(CMD_KERNEL));
                           state_q   <= ST_LEN_HI;
                        end else begin
                           pkt_err_q  <= 1'b1;
                           err_code_q <= ERR_BAD_HDR;
                           state_q    <= ST_IDLE;
                        end
`ifdef UART_LOADER_CHECKSUM_EN
                        sum_q <= bus.r_out;
`endif
                     end
                     ST_LEN_HI: begin
                        len_hi_q <= bus.r_out;
                        state_q  <= ST_LEN_LO;
`ifdef UART_LOADER_CHECKSUM_EN
                        sum_q <= sum_q + bus.r_out;
`endif
                     end
                     ST_LEN_LO: begin
                        if (len_valid(32'({len_hi_q, bus.r_out}), mem_sel_q,
                                      MAX_LEN, KERNEL_DEPTH)) begin
                           len_q   <= {len_hi_q, bus.r_out};
                           idx_q   <= '0;
                           state_q <= ST_PAYLOAD;
                        end else begin
                           pkt_err_q  <= 1'b1;
                           err_code_q <= ERR_BAD_HDR;
                           state_q    <= ST_IDLE;
                        end
`ifdef UART_LOADER_CHECKSUM_EN
                        sum_q <= sum_q + bus.r_out;
`endif
                     end
                     ST_PAYLOAD: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= idx_q;
                        mem_wdata_q <= bus.r_out;
                        idx_q       <= idx_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        sum_q <= sum_q + bus.r_out;
                        if (last_byte) state_q <= ST_CHECK;
`else
                        if (last_byte) state_q <= ST_DONE;
`endif
                     end
`ifdef UART_LOADER_CHECKSUM_EN
                     ST_CHECK: begin
                        if (bus.r_out == sum_q) begin
                           pkt_done_q <= 1'b1;
                        end else begin
                           pkt_err_q  <= 1'b1;
                           err_code_q <= ERR_CHECKSUM;
                        end
                        state_q <= ST_IDLE;
                     end
`endif
                     default: state_q <= ST_IDLE;
                  endcase
               end else if (timeout) begin
                  pkt_err_q  <= 1'b1;
                  err_code_q <= ERR_TIMEOUT;
                  state_q    <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign pkt_done      = pkt_done_q;
   assign pkt_err       = pkt_err_q;
   assign err_code      = err_code_q;
   assign dbg_state_o   = state_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_sel   = mem_sel_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_uart_packet_loader.sv
`timescale 1ns/1ps
module tb_uart_packet_loader;
  import uart_loader_pkg::*;

  localparam int DW = 8;
  localparam int AW = 17;
  localparam int TO = 100;
  localparam int W  = 1 + AW + DW;

  typedef logic [7:0] bq_t[$];

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       busy, pkt_done, pkt_err;
  logic [1:0] err_code;
  state_e     dbg_state;

  always #5 clock = ~clock;

  uart_packet_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uart_packet_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .KERNEL_DEPTH(9),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .busy(busy), .pkt_done(pkt_done), .pkt_err(pkt_err),
    .err_code(err_code), .dbg_state_o(dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_edge_cyc = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clock) cyc++;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin : monitor
    logic [W-1:0] e;
    if (!reset) begin
      if (bus.mem_we) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_write: got sel=%0d addr=%0d data=%02h, expected no write",
                   bus.mem_sel, bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== e) begin
            tests_failed++;
            $display("FAIL write_check: got sel=%0d addr=%0d data=%02h, expected sel=%0d addr=%0d data=%02h",
                     bus.mem_sel, bus.mem_addr, bus.mem_wdata, e[W-1], e[DW+AW-1:DW], e[DW-1:0]);
          end
        end
      end
      if (pkt_done) done_cnt++;
      if (pkt_err) err_cnt++;
      if (pkt_done || pkt_err) begin
        tests_run++;
        if (pkt_done && pkt_err) begin
          tests_failed++;
          $display("FAIL pulse_overlap: got done=1 err=1, expected only one");
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.r_out = b;
    bus.rx_data_ready = 1'b1;
    last_edge_cyc = cyc + 1;
    repeat (3) @(negedge clock);
    bus.rx_data_ready = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  // Walks the byte list by the packet rules, queues the writes it implies and
  // reports how many bytes the loader consumes before the packet resolves.
  task automatic ref_model(input bq_t b, output int used, output bit exp_done,
                           output logic [1:0] exp_code);
    int i;
    int len;
    logic [7:0] cmd;
    logic [7:0] sum;
    bit sel;
    exp_done = 1'b0;
    exp_code = 2'd0;
    i = 0;
    while (i < b.size() && b[i] != 8'hA5) i++;
    i++;
    cmd = b[i];
    i++;
    if (cmd != 8'h01 && cmd != 8'h02) begin
      used = i; exp_code = 2'd1; return;
    end
    sel = (cmd == 8'h02);
    len = {b[i], b[i+1]};
    sum = cmd + b[i] + b[i+1];
    i += 2;
    if (len == 0 || len > (1 << AW) || (sel && len > 9)) begin
      used = i; exp_code = 2'd1; return;
    end
    for (int k = 0; k < len; k++) begin
      exp_q.push_back({sel, AW'(k), b[i]});
      sum = sum + b[i];
      i++;
    end
`ifdef UART_LOADER_CHECKSUM_EN
    if (b[i] == sum) exp_done = 1'b1;
    else exp_code = 2'd3;
    i++;
`else
    exp_done = 1'b1;
`endif
    used = i;
  endtask

`ifdef UART_LOADER_CHECKSUM_EN
  function automatic logic [7:0] chk_of(input bq_t b);
    logic [7:0] s = 8'h00;
    int i = 0;
    while (i < b.size() && b[i] != 8'hA5) i++;
    for (int k = i + 1; k < b.size(); k++) s = s + b[k];
    return s;
  endfunction
`endif

  task automatic build_pkt(input int noise, input logic [7:0] cmd, input int len,
                           input bit bad_chk, output bq_t b);
    logic [7:0] x;
    logic [7:0] sum;
    b.delete();
    for (int k = 0; k < noise; k++) begin
      x = 8'($urandom_range(0, 255));
      if (x == 8'hA5) x = 8'h00;
      b.push_back(x);
    end
    b.push_back(8'hA5);
    b.push_back(cmd);
    b.push_back(8'(len >> 8));
    b.push_back(8'(len));
    sum = cmd + 8'(len >> 8) + 8'(len);
    for (int k = 0; k < len; k++) begin
      x = 8'($urandom_range(0, 255));
      b.push_back(x);
      sum = sum + x;
    end
`ifdef UART_LOADER_CHECKSUM_EN
    b.push_back(bad_chk ? (sum ^ 8'h01) : sum);
`else
    if (bad_chk) sum = 8'h00;
`endif
  endtask

  task automatic run_packet(input bq_t b, input string name);
    int used;
    bit ed;
    logic [1:0] ec;
    int d0, e0;
    ref_model(b, used, ed, ec);
    d0 = done_cnt;
    e0 = err_cnt;
    for (int k = 0; k < used; k++) send_byte(b[k]);
    repeat (8) @(negedge clock);
    tests_run++;
    if ((done_cnt - d0) !== (ed ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL %s done_pulses: got %0d, expected %0d", name, done_cnt - d0, ed ? 1 : 0);
    end
    tests_run++;
    if ((err_cnt - e0) !== (ed ? 0 : 1)) begin
      tests_failed++;
      $display("FAIL %s err_pulses: got %0d, expected %0d", name, err_cnt - e0, ed ? 0 : 1);
    end
    tests_run++;
    if (err_code !== ec) begin
      tests_failed++;
      $display("FAIL %s err_code: got %0d, expected %0d", name, err_code, ec);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy_after: got %0b, expected 0", name, busy);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s missing_writes: got %0d left over, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, busy, pkt_done, pkt_err, err_code} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got we=%0b sel=%0b addr=%0d data=%02h busy=%0b done=%0b err=%0b code=%0d, expected all 0",
               bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, busy, pkt_done, pkt_err, err_code);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, expected IDLE", dbg_state);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_frame_basic;
    bq_t b = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30};
`ifdef UART_LOADER_CHECKSUM_EN
    b.push_back(chk_of(b));
`endif
    run_packet(b, "frame_basic");
    tests_run++;
    if ({bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== {1'b0, 17'd2, 8'h30}) begin
      tests_failed++;
      $display("FAIL frame_hold: got sel=%0d addr=%0d data=%02h, expected sel=0 addr=2 data=30",
               bus.mem_sel, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_kernel_len;
    bq_t b;
    build_pkt(0, 8'h02, 10, 1'b0, b);
    run_packet(b, "kernel_len10");
    build_pkt(0, 8'h02, 9, 1'b0, b);
    run_packet(b, "kernel_len9");
    tests_run++;
    if ({bus.mem_sel, bus.mem_addr} !== {1'b1, 17'd8}) begin
      tests_failed++;
      $display("FAIL kernel_hold: got sel=%0d addr=%0d, expected sel=1 addr=8", bus.mem_sel, bus.mem_addr);
    end
  endtask

  task automatic test_bad_header;
    bq_t b = '{8'hA5, 8'h03};
    run_packet(b, "bad_cmd");
    b = '{8'hA5, 8'h01, 8'h00, 8'h00};
    run_packet(b, "len_zero");
  endtask

  task automatic test_timeout;
    bq_t b = '{8'hA5, 8'h01, 8'h00, 8'h05, 8'h11, 8'h22};
    int e0;
    int waited = -1;
    bit seen = 1'b0;
    exp_q.push_back({1'b0, 17'd0, 8'h11});
    exp_q.push_back({1'b0, 17'd1, 8'h22});
    e0 = err_cnt;
    foreach (b[k]) send_byte(b[k]);
    for (int k = 0; k < 3 * TO && !seen; k++) begin
      @(negedge clock);
      if (pkt_err) begin
        seen = 1'b1;
        waited = cyc - last_edge_cyc;
      end
    end
    tests_run++;
    if (!seen || waited < TO || waited > TO + 1) begin
      tests_failed++;
      $display("FAIL timeout_latency: got %0d cycles (seen=%0b), expected %0d..%0d", waited, seen, TO, TO + 1);
    end
    tests_run++;
    if (err_code !== 2'd2) begin
      tests_failed++;
      $display("FAIL timeout_code: got %0d, expected 2", err_code);
    end
    repeat (3) @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || (err_cnt - e0) !== 1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL timeout_after: got busy=%0b errs=%0d left=%0d, expected busy=0 errs=1 left=0",
               busy, err_cnt - e0, exp_q.size());
    end
    exp_q.delete();
  endtask

`ifdef UART_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    bq_t b = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h7F, 8'h81};
    run_packet(b, "chk_good");
    b = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h7F, 8'h80};
    run_packet(b, "chk_bad");
  endtask
`endif

  task automatic test_noise;
    bq_t b = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h00, 8'h01, 8'hA5};
`ifdef UART_LOADER_CHECKSUM_EN
    b.push_back(chk_of(b));
`endif
    run_packet(b, "noise_sync_data");
  endtask

  task automatic test_reset_mid;
    bq_t b = '{8'hA5, 8'h01, 8'h00, 8'h05, 8'h33, 8'h44};
    int d0, e0;
    exp_q.push_back({1'b0, 17'd0, 8'h33});
    exp_q.push_back({1'b0, 17'd1, 8'h44});
    foreach (b[k]) send_byte(b[k]);
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, busy, pkt_done, pkt_err, err_code} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got we=%0b addr=%0d data=%02h busy=%0b code=%0d, expected all 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, err_code);
    end
    reset = 1'b0;
    repeat (2 * TO) @(negedge clock);
    tests_run++;
    if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_quiet: got done=%0d err=%0d left=%0d, expected 0 0 0",
               done_cnt - d0, err_cnt - e0, exp_q.size());
    end
    exp_q.delete();
    build_pkt(0, 8'h01, 4, 1'b0, b);
    run_packet(b, "after_reset");
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) begin
      bq_t b;
      logic [7:0] cmd;
      int len, r;
      r = $urandom_range(0, 9);
      cmd = (r == 0) ? 8'($urandom_range(3, 255)) : ((r < 5) ? 8'h01 : 8'h02);
      len = (cmd == 8'h02) ? $urandom_range(1, 11) : $urandom_range(1, 24);
      if ($urandom_range(0, 9) == 0) len = 0;
      build_pkt($urandom_range(0, 2), cmd, len, ($urandom_range(0, 4) == 0), b);
      run_packet(b, "random");
    end
  endtask

  initial begin
    bus.rx_data_ready = 1'b0;
    bus.r_out = 8'h00;
    test_reset();
    test_frame_basic();
    test_kernel_len();
    test_bad_header();
    test_timeout();
`ifdef UART_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_noise();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
